// File: rtl/tsmall_weight_sampler_if.sv
// Signal bundle between the fixed-weight sampler, its RNG source, the r coefficient RAM
// and the key-generation sequencer. The sampler uses the master modport.
interface tsmall_weight_sampler_if #(
    parameter int AW = 10,
    parameter int DW = 12
);
    logic          start;
    logic          busy;
    logic          done;
    logic [AW:0]   rnd_data;
    logic          rnd_valid;
    logic          rnd_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] nz_count;
    logic [15:0]   reject_count;

    modport master (
        input  start, rnd_data, rnd_valid, mem_rdata,
        output busy, done, rnd_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
               nz_count, reject_count
    );

    modport slave (
        output start, rnd_data, rnd_valid, mem_rdata,
        input  busy, done, rnd_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
               nz_count, reject_count
    );
endinterface

// File: rtl/tsmall_weight_sampler.sv
// Fills the small-polynomial RAM with a ternary polynomial of exactly W nonzero (+1/-1) entries:
// clear every address, then place random indices, rejecting out-of-range and occupied slots.
module tsmall_weight_sampler #(
    parameter int P  = 677,
    parameter int W  = 202,
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tsmall_weight_sampler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_READ,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [AW:0]   P_EXT     = (AW+1)'(P);
    localparam logic [AW:0]   W_EXT     = (AW+1)'(W);
    localparam logic [AW-1:0] LAST_ADDR = AW'(P - 1);
    localparam logic [DW-1:0] CODE_POS  = DW'(1);
    localparam logic [DW-1:0] CODE_NEG  = DW'(3);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          sign_q, sign_d;
    logic [AW-1:0] nz_q, nz_d;
    logic [15:0]   rej_q, rej_d;

    logic          in_range;
    logic          slot_free;
    logic [AW:0]   nz_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_range  = ({1'b0, bus.rnd_data[AW-1:0]} < P_EXT);
    assign slot_free = (bus.mem_rdata == '0);
    assign nz_inc    = {1'b0, nz_q} + (AW+1)'(1);

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            sign_q  <= 1'b0;
            nz_q    <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            sign_q  <= sign_d;
            nz_q    <= nz_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        // NOTE: defaults first on every variable of a combinational block, otherwise a latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        sign_d  = sign_q;
        nz_d    = nz_q;
        rej_d   = rej_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    nz_d    = '0;
                    rej_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = (W == 0) ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (bus.rnd_valid) begin
                    if (in_range) begin
                        raddr_d = bus.rnd_data[AW-1:0];
                        sign_d  = bus.rnd_data[AW];
                        state_d = S_READ;
                    end else begin
                        rej_d = sat_inc(rej_q);
                    end
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                if (!slot_free) begin
                    rej_d   = sat_inc(rej_q);
                    state_d = S_DRAW;
                end else begin
                    nz_d    = nz_inc[AW-1:0];
                    state_d = (nz_inc == W_EXT) ? S_DONE : S_DRAW;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raddr doubles as the write address in CHECK: it still holds the index being placed.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = cnt_q;
            end
            S_CHECK: begin
                if (slot_free) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = raddr_q;
                    bus.mem_wdata = sign_q ? CODE_NEG : CODE_POS;
                end
            end
            default: ;
        endcase
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.rnd_ready = (state_q == S_DRAW);
    end

    assign bus.mem_raddr    = raddr_q;
    assign bus.nz_count     = nz_q;
    assign bus.reject_count = rej_q;
endmodule
